// File: rtl/sap_pkg.sv
// Shared constants for the SAP output port.
//   ST_IDLE..ST_STOP : 2-bit serializer FSM state encodings
//   START_BIT/STOP_BIT: serial line levels framing each word
package sap_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_START = 2'd1;
  localparam logic [1:0] ST_DATA  = 2'd2;
  localparam logic [1:0] ST_STOP  = 2'd3;

  localparam logic START_BIT = 1'b0;
  localparam logic STOP_BIT  = 1'b1;

endpackage : sap_pkg

// File: rtl/out_serializer_bit_timer.sv
// Bit-period divider for the serializer.
//   clk, clr_n : clock, async active-low clear
//   restart    : hold the divider at the start of a bit period
//   bit_end    : registered, high during the last cycle of each bit period
module bit_timer #(
  parameter int unsigned CLKS_PER_BIT = 4
) (
  input  logic clk,
  input  logic clr_n,
  input  logic restart,
  output logic bit_end
);

  localparam int unsigned CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  // With the counter at 0 the period ends immediately only for one-cycle bits.
  localparam logic END_AT_ZERO = (CLKS_PER_BIT == 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             end_q, end_d;

  // Next count; end flag is precomputed so bit_end comes straight from a flop.
  always_comb begin
    cnt_d = cnt_q + CNT_W'(1);
    if (restart || end_q) begin
      cnt_d = '0;
    end
    end_d = (cnt_d == CNT_LAST);
  end

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      cnt_q <= '0;
      end_q <= END_AT_ZERO;
    end else begin
      cnt_q <= cnt_d;
      end_q <= end_d;
    end
  end

  assign bit_end = end_q;

endmodule : bit_timer

// File: rtl/out_serializer.sv
// Transmit side of the SAP output port: start bit, DATA_WIDTH data bits LSB
// first, stop bit, each held CLKS_PER_BIT clocks.
//   clk, clr_n : clock, async active-low clear
//   i_en, d    : load strobe and parallel word (accepted when i_en && o_ready)
//   o_tx       : serial line, idles high
//   o_ready    : load will be accepted this cycle
//   o_busy     : frame in progress
//   o_done     : one-cycle pulse after the last stop-bit cycle
module out_serializer
  import sap_pkg::*;
#(
  parameter int unsigned DATA_WIDTH   = 8,
  parameter int unsigned CLKS_PER_BIT = 4
) (
  input  logic                  clk,
  input  logic                  clr_n,
  input  logic                  i_en,
  input  logic [DATA_WIDTH-1:0] d,
  output logic                  o_tx,
  output logic                  o_ready,
  output logic                  o_busy,
  output logic                  o_done
);

  localparam int unsigned IDX_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_WIDTH - 1);

  logic [1:0]            state_q, state_d;
  logic [DATA_WIDTH-1:0] shift_q, shift_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic                  tx_q, tx_d;
  logic                  ready_q, ready_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  bit_end;
  logic                  timer_restart;

  // Divider is held at zero while idle so START always gets a full period.
  assign timer_restart = (state_q == ST_IDLE);

  bit_timer #(
    .CLKS_PER_BIT (CLKS_PER_BIT)
  ) u_bit_timer (
    .clk     (clk),
    .clr_n   (clr_n),
    .restart (timer_restart),
    .bit_end (bit_end)
  );

  // Next-state, datapath and output decode.
  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    idx_d   = idx_q;
    done_d  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (i_en && ready_q) begin
          shift_d = d;
          idx_d   = '0;
          state_d = ST_START;
        end
      end
      ST_START: begin
        if (bit_end) begin
          idx_d   = '0;
          state_d = ST_DATA;
        end
      end
      ST_DATA: begin
        if (bit_end) begin
          if (idx_q == IDX_LAST) begin
            state_d = ST_STOP;
          end else begin
            shift_d = shift_q >> 1;
            idx_d   = idx_q + IDX_W'(1);
          end
        end
      end
      ST_STOP: begin
        if (bit_end) begin
          done_d  = 1'b1;
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Outputs follow the next state so they change on the same edge as the FSM.
    case (state_d)
      ST_START: tx_d = START_BIT;
      ST_DATA:  tx_d = shift_d[0];
      default:  tx_d = STOP_BIT;
    endcase
    ready_d = (state_d == ST_IDLE);
    busy_d  = !ready_d;
  end

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      state_q <= ST_IDLE;
      shift_q <= '0;
      idx_q   <= '0;
      tx_q    <= 1'b1;
      ready_q <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      idx_q   <= idx_d;
      tx_q    <= tx_d;
      ready_q <= ready_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign o_tx    = tx_q;
  assign o_ready = ready_q;
  assign o_busy  = busy_q;
  assign o_done  = done_q;

endmodule : out_serializer
